// File: rtl/lcv_mul_acc_pkg.sv
// rtl/lcv_mul_acc_pkg.sv - shared widths and record types for the shared MAC arbiter
package lcv_mul_acc_pkg;

  localparam int DEF_MUL_WIDTH = 16;
  localparam int DEF_ACC_WIDTH = 33;
  localparam int DEF_NUM_REQ   = 4;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_WIDTH = id_w(DEF_NUM_REQ);

  typedef struct packed {
    logic [ID_WIDTH-1:0]      id;
    logic [DEF_MUL_WIDTH-1:0] a;
    logic [DEF_MUL_WIDTH-1:0] b;
    logic [DEF_ACC_WIDTH-1:0] c;
  } op_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]      id;
    logic [DEF_ACC_WIDTH-1:0] data;
  } res_t;

endpackage

// File: rtl/lcv_mul_acc_pipe.sv
// rtl/lcv_mul_acc_pipe.sv - LATENCY-stage signed a*b+c datapath with valid/id sideband
module lcv_mul_acc_pipe
  import lcv_mul_acc_pkg::*;
#(
  parameter int IDW       = 2,
  parameter int MUL_WIDTH = DEF_MUL_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int LATENCY   = 1,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IDW-1:0]       in_id,
  input  logic [MUL_WIDTH-1:0] in_a,
  input  logic [MUL_WIDTH-1:0] in_b,
  input  logic [ACC_WIDTH-1:0] in_c,
  output logic                 out_valid,
  output logic [IDW-1:0]       out_id,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     inflight
);

  localparam int PROD_W = 2 * MUL_WIDTH;

  logic signed [PROD_W-1:0] product;
  (* use_dsp = "yes" *) logic signed [ACC_WIDTH-1:0] mac;

  logic [LATENCY-1:0]   vld;
  logic [IDW-1:0]       id_q   [LATENCY];
  logic [ACC_WIDTH-1:0] data_q [LATENCY];

  // Sized casts of signed operands sign-extend; the sum wraps at ACC_WIDTH.
  assign product = PROD_W'($signed(in_a)) * PROD_W'($signed(in_b));
  assign mac     = ACC_WIDTH'(product) + $signed(in_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int k = 1; k < LATENCY; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    id_q[0]   <= in_id;
    data_q[0] <= mac;
    for (int k = 1; k < LATENCY; k++) begin
      id_q[k]   <= id_q[k-1];
      data_q[k] <= data_q[k-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) begin
      inflight = inflight + CNT_W'(vld[k]);
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_id    = id_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/lcv_mul_acc_arb.sv
// rtl/lcv_mul_acc_arb.sv - round-robin sharing of one pipelined MAC with credit-guarded response FIFO
module lcv_mul_acc_arb
  import lcv_mul_acc_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int MUL_WIDTH   = DEF_MUL_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int MAC_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*MUL_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*MUL_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*ACC_WIDTH-1:0] req_c,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [ACC_WIDTH-1:0]         resp_data
);

  localparam int IDW   = id_w(NUM_REQ);
  localparam int DEPTH = MAC_LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 2) + 1;

  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       grant_idx;
  logic                 grant_found;
  logic                 credit_ok;
  logic                 accept;
  logic                 pop;
  logic                 push;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        inflight;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [IDW-1:0]       fifo_id   [DEPTH];
  logic [ACC_WIDTH-1:0] fifo_data [DEPTH];
  logic                 pipe_valid;
  logic [IDW-1:0]       pipe_id;
  logic [ACC_WIDTH-1:0] pipe_data;
  logic [MUL_WIDTH-1:0] sel_a;
  logic [MUL_WIDTH-1:0] sel_b;
  logic [ACC_WIDTH-1:0] sel_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(j);
      end
    end
  end

  // A pop this cycle frees a slot in time for the op accepted now.
  assign pop       = resp_valid & resp_ready;
  assign credit_ok = (fifo_count + inflight) < (CW'(DEPTH) + CW'(pop));
  assign accept    = grant_found & credit_ok;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  assign sel_a = req_a[int'(grant_idx)*MUL_WIDTH +: MUL_WIDTH];
  assign sel_b = req_b[int'(grant_idx)*MUL_WIDTH +: MUL_WIDTH];
  assign sel_c = req_c[int'(grant_idx)*ACC_WIDTH +: ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= IDW'(NUM_REQ - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

  lcv_mul_acc_pipe #(
    .IDW       (IDW),
    .MUL_WIDTH (MUL_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .LATENCY   (MAC_LATENCY),
    .CNT_W     (CW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_id     (grant_idx),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .in_c      (sel_c),
    .out_valid (pipe_valid),
    .out_id    (pipe_id),
    .out_data  (pipe_data),
    .inflight  (inflight)
  );

  assign push = pipe_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr]   <= pipe_id;
      fifo_data[wr_ptr] <= pipe_data;
    end
  end

  // Outputs are forced to zero when empty so stale slots never leak out.
  assign resp_valid = (fifo_count != '0);
  assign resp_id    = resp_valid ? fifo_id[rd_ptr] : '0;
  assign resp_data  = resp_valid ? fifo_data[rd_ptr] : '0;

endmodule

// File: tb/tb_lcv_mul_acc_arb.sv
// tb/tb_lcv_mul_acc_arb.sv - scoreboard bench for the shared MAC arbiter
module tb_lcv_mul_acc_arb;
  import lcv_mul_acc_pkg::*;

  localparam int N  = 4;
  localparam int MW = 16;
  localparam int AW = 33;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*MW-1:0] req_a;
  logic [N*MW-1:0] req_b;
  logic [N*AW-1:0] req_c;
  logic            resp_valid;
  logic            resp_ready;
  logic [1:0]      resp_id;
  logic [AW-1:0]   resp_data;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  longint t2_data [4] = '{10, 1020, 2030, 3040};

  always #5 clk = ~clk;

  lcv_mul_acc_arb #(.NUM_REQ(N), .MUL_WIDTH(MW), .ACC_WIDTH(AW), .MAC_LATENCY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic set_op(input int i, input longint a, input longint b, input longint c);
    req_a[i*MW +: MW] = MW'(a);
    req_b[i*MW +: MW] = MW'(b);
    req_c[i*AW +: AW] = AW'(c);
  endtask

  task automatic push_exp(input int id, input longint data);
    exp_q.push_back('{id: ID_WIDTH'(id), data: DEF_ACC_WIDTH'(data)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    step();
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_unexpected: got id=%0d data=%0h, required no response", resp_id, resp_data);
      end else begin
        check("resp_id", 64'(resp_id), 64'(exp_q[0].id));
        check("resp_data", 64'(resp_data), 64'(exp_q[0].data));
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, required finish before 100000");
    $fatal(1, "bench stopped");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    resp_ready = 1'b1;
    do_reset();

    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);

    // single op from requester 2
    step();
    mon_en = 1'b1;
    set_op(2, 3, -4, 100);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t1_ready", 64'(req_ready), 64'b0100);
    push_exp(2, 88);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_cycle1_valid", 64'(resp_valid), 64'd0);
    step();
    @(negedge clk);
    check("t1_cycle2_valid", 64'(resp_valid), 64'd1);
    step();
    drain();

    // all requesters, full throughput
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10, i * 1000);
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t2_grant", 64'(req_ready), 64'd1 << (k % 4));
      push_exp(k % 4, t2_data[k % 4]);
      step();
    end
    req_valid = '0;
    drain();

    // backpressure
    do_reset();
    resp_ready = 1'b0;
    set_op(0, 5, 6, 7);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t3_acc0", 64'(req_ready), 64'b0001);
    push_exp(0, 37);
    step();
    set_op(0, 5, 6, 8);
    @(negedge clk);
    check("t3_acc1", 64'(req_ready), 64'b0001);
    push_exp(0, 38);
    step();
    set_op(0, 5, 6, 9);
    @(negedge clk);
    check("t3_full0", 64'(req_ready), 64'd0);
    step();
    @(negedge clk);
    check("t3_full1", 64'(req_ready), 64'd0);
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    check("t3_resume", 64'(req_ready), 64'b0001);
    push_exp(0, 39);
    step();
    req_valid = '0;
    drain();

    // 33-bit wraparound
    set_op(3, -32768, -32768, 64'd4294967295);
    req_valid = 4'b1000;
    @(negedge clk);
    check("t4_ready", 64'(req_ready), 64'b1000);
    push_exp(3, -64'sd3221225473);
    step();
    req_valid = '0;
    drain();

    // fairness between requesters 1 and 3
    set_op(1, 2, 3, -10);
    req_valid = 4'b0010;
    @(negedge clk);
    check("t5_prime", 64'(req_ready), 64'b0010);
    push_exp(1, -4);
    step();
    set_op(3, -7, 5, 0);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_grant", 64'(req_ready), (k % 2 == 0) ? 64'b1000 : 64'b0010);
      if (k % 2 == 0) push_exp(3, -35);
      else push_exp(1, -4);
      step();
    end
    req_valid = '0;
    drain();

    // reset with operations in flight
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) set_op(i, i + 2, 3, 1);
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_grant", 64'(req_ready), 64'd1 << k);
      step();
    end
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t6_no_stray", 64'(resp_valid), 64'd0);
      step();
    end
    set_op(0, 1, 1, 1);
    set_op(1, 2, 2, 2);
    req_valid = 4'b0011;
    @(negedge clk);
    check("t6_first", 64'(req_ready), 64'b0001);
    push_exp(0, 2);
    step();
    req_valid = 4'b0010;
    @(negedge clk);
    check("t6_second", 64'(req_ready), 64'b0010);
    push_exp(1, 6);
    step();
    req_valid = '0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
